// File: rtl/cordic_angle_ctrl.sv
`default_nettype none
// ============================================================================
// Module  : cordic_angle_ctrl
// Purpose : Z-path sequencer for an iterative CORDIC rotator. Emits one
//           direction bit per micro-rotation and the final residual angle.
// Rev     : 1.0  initial release
// ============================================================================
module cordic_angle_ctrl #(
    parameter int WIDTH  = 22,
    parameter int N_ITER = 16,
    parameter int IDX_W  = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] z_in,
    output logic             quad_flip,
    output logic             b_out,
    output logic [IDX_W-1:0] stage_idx,
    output logic             stage_valid,
    output logic             done,
    output logic [WIDTH-1:0] z_resid
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_DONE = 2'd2
    } state_e;

    // The arctangent table is held at 22-bit angle resolution and rescaled
    // (with rounding when narrowing) for other widths.
    localparam int          c_UP_SHIFT = (WIDTH >= 22) ? (WIDTH - 22) : 0;
    localparam int          c_DN_SHIFT = (WIDTH <  22) ? (22 - WIDTH) : 0;
    localparam logic [63:0] c_RND      = (64'd1 << c_DN_SHIFT) >> 1;

    localparam logic [IDX_W-1:0] c_LAST    = IDX_W'(N_ITER - 1);
    localparam logic [WIDTH-1:0] c_QUARTER = WIDTH'(1) << (WIDTH - 2);

    function automatic logic [WIDTH-1:0] atan_rom(input logic [IDX_W-1:0] idx);
        logic [63:0] base;
        case (int'(idx))
            0:       base = 64'd524288;
            1:       base = 64'd309506;
            2:       base = 64'd163534;
            3:       base = 64'd83012;
            4:       base = 64'd41667;
            5:       base = 64'd20854;
            6:       base = 64'd10430;
            7:       base = 64'd5215;
            8:       base = 64'd2608;
            9:       base = 64'd1304;
            10:      base = 64'd652;
            11:      base = 64'd326;
            12:      base = 64'd163;
            13:      base = 64'd81;
            14:      base = 64'd41;
            15:      base = 64'd20;
            default: base = 64'd0;
        endcase
        return WIDTH'(((base << c_UP_SHIFT) + c_RND) >> c_DN_SHIFT);
    endfunction

    state_e             state_q,       state_d;
    logic [WIDTH-1:0]   z_q,           z_d;
    logic               quad_flip_q,   quad_flip_d;
    logic               b_q,           b_d;
    logic [IDX_W-1:0]   stage_idx_q,   stage_idx_d;
    logic               stage_valid_q, stage_valid_d;
    logic               done_q,        done_d;
    logic [WIDTH-1:0]   z_resid_q,     z_resid_d;
    logic               in_ready_q,    in_ready_d;

    logic [WIDTH-1:0]   w_atan;
    logic               w_fold;

    // Angles beyond +/-pi/2 are moved by pi; the boundaries themselves stay.
    assign w_fold = ($signed(z_in) > $signed(c_QUARTER)) ||
                    ($signed(z_in) < -$signed(c_QUARTER));
    assign w_atan = atan_rom(stage_idx_q);

    always_comb begin
        state_d       = state_q;
        z_d           = z_q;
        quad_flip_d   = quad_flip_q;
        b_d           = 1'b0;
        stage_idx_d   = '0;
        stage_valid_d = 1'b0;
        done_d        = 1'b0;
        z_resid_d     = z_resid_q;
        in_ready_d    = 1'b0;

        case (state_q)
            S_IDLE: begin
                in_ready_d = 1'b1;
                if (in_valid && in_ready_q) begin
                    z_d           = w_fold ? {~z_in[WIDTH-1], z_in[WIDTH-2:0]} : z_in;
                    quad_flip_d   = w_fold;
                    state_d       = S_RUN;
                    stage_valid_d = 1'b1;
                    b_d           = ~z_d[WIDTH-1];
                    in_ready_d    = 1'b0;
                end
            end
            S_RUN: begin
                z_d = b_q ? (z_q - w_atan) : (z_q + w_atan);
                if (stage_idx_q == c_LAST) begin
                    state_d   = S_DONE;
                    done_d    = 1'b1;
                    z_resid_d = z_d;
                end else begin
                    stage_valid_d = 1'b1;
                    stage_idx_d   = stage_idx_q + 1'b1;
                    b_d           = ~z_d[WIDTH-1];
                end
            end
            S_DONE: begin
                state_d    = S_IDLE;
                in_ready_d = 1'b1;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q       <= S_IDLE;
            z_q           <= '0;
            quad_flip_q   <= 1'b0;
            b_q           <= 1'b0;
            stage_idx_q   <= '0;
            stage_valid_q <= 1'b0;
            done_q        <= 1'b0;
            z_resid_q     <= '0;
            in_ready_q    <= 1'b0;
        end else begin
            state_q       <= state_d;
            z_q           <= z_d;
            quad_flip_q   <= quad_flip_d;
            b_q           <= b_d;
            stage_idx_q   <= stage_idx_d;
            stage_valid_q <= stage_valid_d;
            done_q        <= done_d;
            z_resid_q     <= z_resid_d;
            in_ready_q    <= in_ready_d;
        end
    end

    assign in_ready    = in_ready_q;
    assign quad_flip   = quad_flip_q;
    assign b_out       = b_q;
    assign stage_idx   = stage_idx_q;
    assign stage_valid = stage_valid_q;
    assign done        = done_q;
    assign z_resid     = z_resid_q;

endmodule
`default_nettype wire

// File: tb/tb_cordic_angle_ctrl.sv
`default_nettype none
// ============================================================================
// Module  : tb_cordic_angle_ctrl
// Purpose : Directed and randomised self-checking bench for cordic_angle_ctrl.
// Rev     : 1.0  initial release
// ============================================================================
module tb_cordic_angle_ctrl;

    localparam int WIDTH  = 22;
    localparam int N_ITER = 16;
    localparam int IDX_W  = 4;

    localparam int ATAN [16] = '{524288, 309506, 163534, 83012, 41667, 20854,
                                 10430, 5215, 2608, 1304, 652, 326, 163, 81, 41, 20};

    logic             clk = 1'b0;
    logic             rst_n = 1'b0;
    logic             in_valid = 1'b0;
    logic             in_ready;
    logic [WIDTH-1:0] z_in = '0;
    logic             quad_flip;
    logic             b_out;
    logic [IDX_W-1:0] stage_idx;
    logic             stage_valid;
    logic             done;
    logic [WIDTH-1:0] z_resid;

    int total = 0;
    int bad   = 0;

    cordic_angle_ctrl #(.WIDTH(WIDTH), .N_ITER(N_ITER), .IDX_W(IDX_W)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .z_in       (z_in),
        .quad_flip  (quad_flip),
        .b_out      (b_out),
        .stage_idx  (stage_idx),
        .stage_valid(stage_valid),
        .done       (done),
        .z_resid    (z_resid)
    );

    always #5 clk = ~clk;

    // Golden model: fold by pi outside +/-pi/2, then 16 signed micro-rotations.
    function automatic void ref_model(input logic [WIDTH-1:0] zin, output logic qf,
                                      output logic [15:0] bs, output logic [WIDTH-1:0] resid);
        int z;
        z  = int'($signed(zin));
        qf = (z > 1048576) || (z < -1048576);
        if (qf) begin
            z = z + 2097152;
            if (z >= 2097152) z = z - 4194304;
        end
        bs = '0;
        for (int i = 0; i < N_ITER; i++) begin
            bs[i] = (z >= 0);
            z     = bs[i] ? (z - ATAN[i]) : (z + ATAN[i]);
        end
        resid = WIDTH'(z);
    endfunction

    // Drives one angle and records what the DUT produced; comparisons live in the tests.
    task automatic do_run(input logic [WIDTH-1:0] zin, output logic acc_ok, output logic qf,
                          output logic [15:0] bs, output logic [WIDTH-1:0] resid,
                          output int lat, output logic idx_ok);
        int k;
        k = 0; acc_ok = 1'b0; qf = 1'b0; bs = '0; resid = '0; lat = -1; idx_ok = 1'b1;
        for (int w = 0; w < 40 && !acc_ok; w++) begin
            @(negedge clk);
            if (in_ready === 1'b1) acc_ok = 1'b1;
        end
        if (!acc_ok) return;
        in_valid = 1'b1;
        z_in     = zin;
        for (int c = 1; c <= 40; c++) begin
            @(negedge clk);
            if (c == 1) begin
                in_valid = 1'b0;
                z_in     = WIDTH'($urandom);
            end
            if (stage_valid === 1'b1) begin
                if (stage_idx !== IDX_W'(k) || c != k + 1) idx_ok = 1'b0;
                if (k == 0) qf = quad_flip;
                bs[stage_idx] = b_out;
                k++;
            end
            if (done === 1'b1) begin
                resid = z_resid;
                lat   = c;
                break;
            end
        end
        if (k != N_ITER) idx_ok = 1'b0;
    endtask

    task automatic test_reset();
        rst_n = 1'b0; in_valid = 1'b0;
        repeat (3) @(negedge clk);
        total++;
        if ({in_ready, quad_flip, b_out, stage_idx, stage_valid, done, z_resid} !== '0) begin
            bad++;
            $display("FAIL reset_outputs: got rdy=%b qf=%b b=%b idx=%0d sv=%b done=%b resid=%h want all 0",
                     in_ready, quad_flip, b_out, stage_idx, stage_valid, done, z_resid);
        end
        rst_n = 1'b1;
        @(negedge clk);
        total++;
        if (in_ready !== 1'b1) begin
            bad++; $display("FAIL reset_release_ready: got %b want 1", in_ready);
        end
    endtask

    task automatic test_zero();
        logic acc, qf, iok; logic [15:0] bs; logic [WIDTH-1:0] r; int lat;
        do_run(22'd0, acc, qf, bs, r, lat, iok);
        total++; if (acc !== 1'b1) begin bad++; $display("FAIL zero_accept: got %b want 1", acc); end
        total++; if (qf !== 1'b0) begin bad++; $display("FAIL zero_qflip: got %b want 0", qf); end
        total++; if (bs !== 16'h30D1) begin bad++; $display("FAIL zero_bseq: got %h want 30d1", bs); end
        total++; if (lat !== 17) begin bad++; $display("FAIL zero_latency: got %0d want 17", lat); end
        total++; if (r !== 22'd13) begin bad++; $display("FAIL zero_resid: got %h want 00000d", r); end
    endtask

    task automatic test_45deg();
        logic acc, qf, iok; logic [15:0] bs; logic [WIDTH-1:0] r; int lat;
        do_run(22'd524288, acc, qf, bs, r, lat, iok);
        total++; if (qf !== 1'b0) begin bad++; $display("FAIL p45_qflip: got %b want 0", qf); end
        total++; if (bs !== 16'hAF83) begin bad++; $display("FAIL p45_bseq: got %h want af83", bs); end
        total++; if (iok !== 1'b1) begin bad++; $display("FAIL p45_stage_idx_seq: got %b want 1", iok); end
        total++; if (r !== 22'h3FFFF5) begin bad++; $display("FAIL p45_resid: got %h want 3ffff5", r); end
    endtask

    task automatic test_fold();
        logic [WIDTH-1:0] vz [6] = '{22'h100000, 22'h100001, 22'h300000,
                                     22'h2FFFFF, 22'h0FFFFF, 22'h3FFFFF};
        logic             vq [6] = '{1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0};
        logic             vb [6] = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0};
        logic acc, qf, iok, mq; logic [15:0] bs, mbs; logic [WIDTH-1:0] r, mr; int lat;
        for (int i = 0; i < 6; i++) begin
            do_run(vz[i], acc, qf, bs, r, lat, iok);
            ref_model(vz[i], mq, mbs, mr);
            total++;
            if (qf !== vq[i]) begin
                bad++; $display("FAIL fold_qflip z=%h: got %b want %b", vz[i], qf, vq[i]);
            end
            total++;
            if (bs[0] !== vb[i]) begin
                bad++; $display("FAIL fold_b0 z=%h: got %b want %b", vz[i], bs[0], vb[i]);
            end
            total++;
            if (r !== mr) begin
                bad++; $display("FAIL fold_resid z=%h: got %h want %h", vz[i], r, mr);
            end
        end
        // -pi folds onto zero, so it must replay the z=0 run exactly
        do_run(22'h200000, acc, qf, bs, r, lat, iok);
        total++; if (qf !== 1'b1) begin bad++; $display("FAIL mpi_qflip: got %b want 1", qf); end
        total++; if (bs !== 16'h30D1) begin bad++; $display("FAIL mpi_bseq: got %h want 30d1", bs); end
        total++; if (r !== 22'd13) begin bad++; $display("FAIL mpi_resid: got %h want 00000d", r); end
    endtask

    task automatic test_abort();
        int ndone; logic ok;
        ok = 1'b0;
        for (int w = 0; w < 40 && !ok; w++) begin
            @(negedge clk);
            if (in_ready === 1'b1) ok = 1'b1;
        end
        in_valid = 1'b1; z_in = 22'h0ABCDE;
        @(negedge clk);
        in_valid = 1'b0;
        repeat (4) @(negedge clk);
        total++;
        if (stage_valid !== 1'b1) begin bad++; $display("FAIL abort_running: got sv=%b want 1", stage_valid); end
        rst_n = 1'b0;
        repeat (3) @(negedge clk);
        total++;
        if ({in_ready, quad_flip, b_out, stage_idx, stage_valid, done, z_resid} !== '0) begin
            bad++;
            $display("FAIL abort_reset_outputs: got rdy=%b qf=%b b=%b idx=%0d sv=%b done=%b resid=%h want all 0",
                     in_ready, quad_flip, b_out, stage_idx, stage_valid, done, z_resid);
        end
        rst_n = 1'b1;
        @(negedge clk);
        total++;
        if (in_ready !== 1'b1) begin bad++; $display("FAIL abort_release_ready: got %b want 1", in_ready); end
        ndone = 0;
        repeat (20) begin
            @(negedge clk);
            if (done === 1'b1) ndone++;
        end
        total++;
        if (ndone != 0) begin bad++; $display("FAIL abort_no_done: got %0d pulses want 0", ndone); end
    endtask

    task automatic test_back_to_back();
        int d1, s2, k2; logic [WIDTH-1:0] r1, r2; logic [15:0] bs2; logic rdy_after;
        d1 = -1; s2 = -1; k2 = 0; r1 = 'x; r2 = 'x; bs2 = '0; rdy_after = 1'b0;
        @(negedge clk);
        in_valid = 1'b1; z_in = 22'd0;
        for (int c = 1; c <= 60; c++) begin
            @(negedge clk);
            if (d1 >= 0 && c == d1 + 1) rdy_after = in_ready;
            if (stage_valid === 1'b1 && d1 >= 0) begin
                if (s2 < 0) begin s2 = c; in_valid = 1'b0; end
                bs2[stage_idx] = b_out;
                k2++;
            end
            if (done === 1'b1) begin
                if (d1 < 0) begin
                    d1 = c; r1 = z_resid; z_in = 22'd524288;
                end else begin
                    r2 = z_resid; break;
                end
            end else if (d1 < 0) begin
                z_in = WIDTH'($urandom);
            end
        end
        in_valid = 1'b0;
        total++; if (r1 !== 22'd13) begin bad++; $display("FAIL b2b_first_resid: got %h want 00000d", r1); end
        total++; if (rdy_after !== 1'b1) begin bad++; $display("FAIL b2b_ready_after_done: got %b want 1", rdy_after); end
        total++;
        if (d1 < 0 || s2 - d1 != 2) begin
            bad++; $display("FAIL b2b_second_accept: got done@%0d stage0@%0d want gap 2", d1, s2);
        end
        total++; if (bs2 !== 16'hAF83) begin bad++; $display("FAIL b2b_second_bseq: got %h want af83", bs2); end
        total++; if (r2 !== 22'h3FFFF5) begin bad++; $display("FAIL b2b_second_resid: got %h want 3ffff5", r2); end
    endtask

    task automatic test_random();
        logic acc, qf, iok, mq; logic [15:0] bs, mbs; logic [WIDTH-1:0] zr, r, mr; int lat;
        for (int n = 0; n < 150; n++) begin
            zr = WIDTH'($urandom);
            do_run(zr, acc, qf, bs, r, lat, iok);
            ref_model(zr, mq, mbs, mr);
            total++;
            if (qf !== mq || bs !== mbs || r !== mr || lat !== 17 || iok !== 1'b1) begin
                bad++;
                $display("FAIL rand z=%h: got qf=%b b=%h resid=%h lat=%0d idx=%b want qf=%b b=%h resid=%h lat=17 idx=1",
                         zr, qf, bs, r, lat, iok, mq, mbs, mr);
            end
        end
    endtask

    initial begin
        test_reset();
        test_zero();
        test_45deg();
        test_fold();
        test_abort();
        test_back_to_back();
        test_random();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached, total=%0d bad=%0d", total, bad);
        $fatal(1, "watchdog");
    end

endmodule
`default_nettype wire
